// File: rtl/pad_in_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pad_in_pkg
// Brief    : Shared defaults and channel map for the pad input conditioner.
// Revision : 1.0
// ============================================================================
package pad_in_pkg;

  localparam int PAD_IN_GPIO_NUM    = 21;
  localparam int PAD_IN_UPIO_NUM    = 8;
  localparam int PAD_IN_NUM         = PAD_IN_GPIO_NUM + PAD_IN_UPIO_NUM;
  localparam int PAD_IN_FILT_W      = 4;
  localparam int PAD_IN_SYNC_STAGES = 2;

  // GPIO occupies the low bits, UPIO sits directly above it
  localparam int PAD_IN_GPIO_LSB    = 0;
  localparam int PAD_IN_UPIO_LSB    = PAD_IN_GPIO_LSB + PAD_IN_GPIO_NUM;

endpackage
`default_nettype wire

// File: rtl/pad_in_filter_chan.sv
`default_nettype none
// ============================================================================
// Module   : pad_in_filter_chan
// Brief    : One pad input channel: synchroniser, debounce, sticky edge event.
// Revision : 1.0
// ============================================================================
module pad_in_filter_chan
  import pad_in_pkg::*;
#(
  parameter int SYNC_STAGES = PAD_IN_SYNC_STAGES,
  parameter int FILT_W      = PAD_IN_FILT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad_in_i,
  input  logic              filt_en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              rise_en_i,
  input  logic              fall_en_i,
  input  logic              ev_clr_i,
  output logic              data_o,
  output logic              ev_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_W-1:0]      r_cnt;
  logic                   r_stable;
  logic                   r_prev;
  logic                   r_ev;
  logic                   w_sync;
  logic [FILT_W-1:0]      w_len_m1;
  logic                   w_set;

  // Pure flop chain so CDC constraints can target this block by name
  always_ff @(posedge clk or negedge rst_n) begin : p_sync_chain
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pad_in_i};
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  // A length of zero behaves as one, so the terminal count bottoms out at 0
  assign w_len_m1 = (filt_len_i == '0) ? '0 : filt_len_i - FILT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin : p_filter
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (!filt_en_i) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else if (w_sync == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt < w_len_m1) begin
      r_cnt    <= r_cnt + FILT_W'(1);
    end else begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end
  end

  assign w_set = (r_stable & ~r_prev & rise_en_i) | (~r_stable & r_prev & fall_en_i);

  always_ff @(posedge clk or negedge rst_n) begin : p_event
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_ev   <= 1'b0;
    end else begin
      r_prev <= r_stable;
      r_ev   <= w_set | (r_ev & ~ev_clr_i);
    end
  end

  assign data_o = r_stable;
  assign ev_o   = r_ev;

endmodule
`default_nettype wire

// File: rtl/pad_in_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pad_in_conditioner
// Brief    : Resynchronises, debounces and edge-detects the pad ring inputs.
// Revision : 1.0
// ============================================================================
module pad_in_conditioner
  import pad_in_pkg::*;
#(
  parameter int NUM_IN      = PAD_IN_NUM,
  parameter int SYNC_STAGES = PAD_IN_SYNC_STAGES,
  parameter int FILT_W      = PAD_IN_FILT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] pad_in_i,
  input  logic [NUM_IN-1:0] filt_en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [NUM_IN-1:0] rise_en_i,
  input  logic [NUM_IN-1:0] fall_en_i,
  input  logic [NUM_IN-1:0] ev_clr_i,
  output logic [NUM_IN-1:0] data_o,
  output logic [NUM_IN-1:0] ev_o,
  output logic              irq_o
);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    pad_in_filter_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .pad_in_i   (pad_in_i[i]),
      .filt_en_i  (filt_en_i[i]),
      .filt_len_i (filt_len_i),
      .rise_en_i  (rise_en_i[i]),
      .fall_en_i  (fall_en_i[i]),
      .ev_clr_i   (ev_clr_i[i]),
      .data_o     (data_o[i]),
      .ev_o       (ev_o[i])
    );
  end

  assign irq_o = |ev_o;

endmodule
`default_nettype wire
